// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data word, RAM handshake state and the arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single RAM port shared by icache (read-only) and dcache (read/write): dcache-first
// priority with a starvation counter that periodically forces an icache grant.
//
// state | meaning
// IDLE  | arbitration bubble, no RAM enables driven
// IGNT  | icache owns the RAM port until ACCESS or abort
// DGNT  | dcache owns the RAM port until ACCESS or abort
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  word_t       iaddr,
  output logic        iwait,
  output word_t       iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  word_t       daddr,
  input  word_t       dstore,
  output logic        dwait,
  output word_t       dload,
  output logic        ramREN,
  output logic        ramWEN,
  output word_t       ramaddr,
  output word_t       ramstore,
  input  word_t       ramload,
  input  ramstate_t   ramstate,
  output logic        timeout
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);

  arb_state_t     state, next_state;
  logic [SCW-1:0] starve_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           i_done, d_done, granted;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state)
      IDLE: begin
        if ((dREN || dWEN) && !(iREN && starve_cnt == SCW'(STARVE_MAX)))
          next_state = DGNT;
        else if (iREN)
          next_state = IGNT;
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait      = 1'b0;
          iload      = ramload;
          i_done     = 1'b1;
          next_state = IDLE;
        end
      end
      DGNT: begin
        ramaddr = daddr;
        // A simultaneous read+write request is serviced as a write only.
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = dREN;
        end
        if (!(dREN || dWEN)) begin
          next_state = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait      = 1'b0;
          dload      = dWEN ? '0 : ramload;
          d_done     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      starve_cnt <= '0;
    else if (i_done)
      starve_cnt <= '0;
    else if (d_done && iREN && starve_cnt != SCW'(STARVE_MAX))
      starve_cnt <= starve_cnt + 1'b1;
  end

  assign granted = (state == IGNT) || (state == DGNT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      wait_cnt <= '0;
    else if (!granted)
      wait_cnt <= '0;
    else if (wait_cnt != WCW'(TIMEOUT))
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Set on the same edge that wait_cnt reaches TIMEOUT so both become visible together.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      timeout <= 1'b0;
    else if (granted && wait_cnt >= WCW'(TIMEOUT - 1))
      timeout <= 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, starvation override, writes, abort,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN, timeout;
  word_t     iload, dload, ramaddr, ramstore;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    ramstate = FREE;
  endtask

  initial begin
    clear_inputs();
    nRST = 1'b0;
    #2;
    chk("rst_state",  32'(dut.state), 32'(IDLE));
    chk("rst_iwait",  32'(iwait), 32'd1);
    chk("rst_dwait",  32'(dwait), 32'd1);
    chk("rst_ramren", 32'(ramREN), 32'd0);
    chk("rst_ramwen", 32'(ramWEN), 32'd0);
    chk("rst_addr",   ramaddr, 32'h0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    #1 nRST = 1'b1;

    // 1: icache alone, ACCESS on the 2nd grant cycle
    tick();
    iREN = 1; iaddr = 32'h40; ramload = 32'h1111_0001; ramstate = BUSY;
    #1;
    chk("t1_idle_ramren", 32'(ramREN), 32'd0);
    tick();
    chk("t1_state_ignt", 32'(dut.state), 32'(IGNT));
    chk("t1_ramren", 32'(ramREN), 32'd1);
    chk("t1_ramaddr", ramaddr, 32'h40);
    chk("t1_iwait_busy", 32'(iwait), 32'd1);
    tick();
    ramstate = ACCESS;
    #1;
    chk("t1_iwait_done", 32'(iwait), 32'd0);
    chk("t1_iload", iload, 32'h1111_0001);
    chk("t1_dwait", 32'(dwait), 32'd1);
    tick();
    iREN = 0; ramstate = FREE;
    #1;
    chk("t1_back_idle", 32'(dut.state), 32'(IDLE));
    chk("t1_iwait_idle", 32'(iwait), 32'd1);

    // 2: simultaneous requests, dcache wins first
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h80; ramstate = BUSY;
    tick();
    chk("t2_state_dgnt", 32'(dut.state), 32'(DGNT));
    chk("t2_ramaddr", ramaddr, 32'h80);
    ramstate = ACCESS; ramload = 32'h2222_0002;
    #1;
    chk("t2_dwait", 32'(dwait), 32'd0);
    chk("t2_dload", dload, 32'h2222_0002);
    chk("t2_iwait", 32'(iwait), 32'd1);
    tick();
    chk("t2_starve1", 32'(dut.starve_cnt), 32'd1);
    dREN = 0; ramstate = BUSY;
    tick();
    chk("t2_state_ignt", 32'(dut.state), 32'(IGNT));
    chk("t2_iaddr", ramaddr, 32'h44);
    ramstate = ACCESS; ramload = 32'h3333_0003;
    #1;
    chk("t2_iload", iload, 32'h3333_0003);
    tick();
    chk("t2_starve0", 32'(dut.starve_cnt), 32'd0);
    clear_inputs();

    // 3: dcache hogging with icache pending; fifth grant goes to icache
    iREN = 1; iaddr = 32'h48; dREN = 1; daddr = 32'h90;
    ramstate = ACCESS; ramload = 32'h4444_0004;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t3_dgnt%0d", k), 32'(dut.state), 32'(DGNT));
      chk($sformatf("t3_dwait%0d", k), 32'(dwait), 32'd0);
      tick();
      chk($sformatf("t3_starve%0d", k), 32'(dut.starve_cnt), 32'(k));
    end
    tick();
    chk("t3_forced_ignt", 32'(dut.state), 32'(IGNT));
    chk("t3_iwait", 32'(iwait), 32'd0);
    chk("t3_dwait_held", 32'(dwait), 32'd1);
    tick();
    chk("t3_starve_clr", 32'(dut.starve_cnt), 32'd0);
    clear_inputs();

    // 4: read+write together is a write
    dREN = 1; dWEN = 1; daddr = 32'hA0; dstore = 32'hDEAD_BEEF;
    ramload = 32'h5555_0005; ramstate = BUSY;
    tick();
    chk("t4_ramwen", 32'(ramWEN), 32'd1);
    chk("t4_ramren", 32'(ramREN), 32'd0);
    chk("t4_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("t4_dwait_busy", 32'(dwait), 32'd1);
    ramstate = ACCESS;
    #1;
    chk("t4_dwait_done", 32'(dwait), 32'd0);
    chk("t4_dload_zero", dload, 32'h0);
    tick();
    clear_inputs();

    // abort: request dropped mid-grant
    dREN = 1; daddr = 32'hC0; ramstate = BUSY;
    tick();
    chk("ab_dgnt", 32'(dut.state), 32'(DGNT));
    dREN = 0;
    #1;
    chk("ab_ramren", 32'(ramREN), 32'd0);
    chk("ab_dwait", 32'(dwait), 32'd1);
    tick();
    chk("ab_idle", 32'(dut.state), 32'(IDLE));
    clear_inputs();

    // 5: RAM stuck BUSY with TIMEOUT=8
    iREN = 1; iaddr = 32'h50; ramstate = BUSY; ramload = 32'h6666_0006;
    tick();
    for (int j = 1; j <= 7; j++) tick();
    chk("t5_no_timeout_yet", 32'(timeout), 32'd0);
    tick();
    chk("t5_timeout_set", 32'(timeout), 32'd1);
    chk("t5_grant_held", 32'(dut.state), 32'(IGNT));
    chk("t5_iwait_held", 32'(iwait), 32'd1);
    tick();
    tick();
    chk("t5_wait_sat", 32'(dut.wait_cnt), 32'd8);
    chk("t5_timeout_sticky", 32'(timeout), 32'd1);
    ramstate = ACCESS;
    #1;
    chk("t5_iwait_release", 32'(iwait), 32'd0);
    tick();
    clear_inputs();
    #1;
    chk("t5_timeout_idle", 32'(timeout), 32'd1);

    // 6: asynchronous reset mid-DGNT
    dWEN = 1; daddr = 32'hB0; dstore = 32'h1234_5678; iREN = 1; ramstate = BUSY;
    tick();
    chk("t6_ramwen_pre", 32'(ramWEN), 32'd1);
    tick();
    nRST = 1'b0;
    #1;
    chk("t6_ramwen", 32'(ramWEN), 32'd0);
    chk("t6_ramren", 32'(ramREN), 32'd0);
    chk("t6_state", 32'(dut.state), 32'(IDLE));
    chk("t6_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    chk("t6_starve", 32'(dut.starve_cnt), 32'd0);
    chk("t6_timeout", 32'(timeout), 32'd0);
    clear_inputs();
    #2 nRST = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
